// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: sits between the EXE/MEM register and the data memory array.
// Each load/store is range- and alignment-checked, converted to a word index,
// and run through an IDLE -> WAIT -> DONE sequence. freeze holds the pipeline
// until the access completes. Illegal requests are counted and never reach
// the memory.
module mem_access_ctrl #(
    parameter logic [31:0] BASE_ADDR   = 32'd1024,
    parameter int          DEPTH_WORDS = 64,
    parameter int          WAIT_CYCLES = 2,
    localparam int         AW          = $clog2(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          MEM_R_EN,
    input  logic          MEM_W_EN,
    input  logic [31:0]   alu_res,
    input  logic [31:0]   rm_val,
    input  logic [31:0]   mem_rdata,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wdata,
    output logic          mem_we,
    output logic          mem_re,
    output logic [31:0]   data_mem,
    output logic          freeze,
    output logic          addr_fault,
    output logic [7:0]    fault_cnt
);

    // Byte address of the last word in the window.
    localparam logic [31:0] LAST_ADDR = BASE_ADDR + 32'(4 * DEPTH_WORDS) - 32'd4;
    localparam logic [3:0]  WC        = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_DONE
    } state_t;

    state_t         state_q, state_d;
    logic [AW-1:0]  idx_q, idx_d;
    logic [31:0]    wdata_q, wdata_d;
    logic           is_load_q, is_load_d;
    logic [3:0]     wcnt_q, wcnt_d;
    logic [31:0]    data_q, data_d;
    logic [7:0]     fcnt_q, fcnt_d;

    logic           req;
    logic           legal;
    logic [31:0]    offset;
    logic [AW-1:0]  idx;
    logic           unused_offset_bits;

    logic           freeze_c;
    logic           fault_c;
    logic           we_c;
    logic           re_c;

    // Request decode: exactly one enable, inside the window, word aligned.
    // An address below BASE_ADDR wraps in offset, but legal is low then and
    // the index is never latched.
    always_comb begin
        req    = MEM_R_EN | MEM_W_EN;
        offset = alu_res - BASE_ADDR;
        idx    = offset[AW+1:2];
        legal  = (MEM_R_EN ^ MEM_W_EN)
               && (alu_res >= BASE_ADDR)
               && (alu_res <= LAST_ADDR)
               && (alu_res[1:0] == 2'b00);
    end

    assign unused_offset_bits = ^{offset[31:AW+2], offset[1:0]};

    // Next-state and strobe logic for the access sequencer.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        wdata_d   = wdata_q;
        is_load_d = is_load_q;
        wcnt_d    = wcnt_q;
        data_d    = data_q;
        fcnt_d    = fcnt_q;
        freeze_c  = 1'b0;
        fault_c   = 1'b0;
        we_c      = 1'b0;
        re_c      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req) begin
                    if (legal) begin
                        freeze_c  = 1'b1;
                        idx_d     = idx;
                        wdata_d   = rm_val;
                        is_load_d = MEM_R_EN;
                        wcnt_d    = WC;
                        state_d   = (WC != 4'd0) ? S_WAIT : S_DONE;
                    end else begin
                        fault_c = 1'b1;
                        if (fcnt_q != 8'hFF) begin
                            fcnt_d = fcnt_q + 8'd1;
                        end
                    end
                end
            end
            S_WAIT: begin
                freeze_c = 1'b1;
                re_c     = is_load_q;
                wcnt_d   = wcnt_q - 4'd1;
                if (wcnt_q <= 4'd1) begin
                    if (is_load_q) begin
                        data_d = mem_rdata;
                    end
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                we_c = ~is_load_q;
                // With no wait states the read happens here instead of WAIT.
                if (is_load_q && (WC == 4'd0)) begin
                    re_c   = 1'b1;
                    data_d = mem_rdata;
                end
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and latch registers; reset drops any pending store.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            idx_q     <= '0;
            wdata_q   <= '0;
            is_load_q <= 1'b0;
            wcnt_q    <= '0;
            data_q    <= '0;
            fcnt_q    <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            wdata_q   <= wdata_d;
            is_load_q <= is_load_d;
            wcnt_q    <= wcnt_d;
            data_q    <= data_d;
            fcnt_q    <= fcnt_d;
        end
    end

    // Combinational strobes are forced low while reset is held so a request
    // still sitting on the inputs cannot freeze or fault during reset.
    assign freeze     = rst & freeze_c;
    assign addr_fault = rst & fault_c;
    assign mem_we     = rst & we_c;
    assign mem_re     = rst & re_c;

    assign mem_addr   = idx_q;
    assign mem_wdata  = wdata_q;
    assign data_mem   = data_q;
    assign fault_cnt  = fcnt_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: a default build (2 wait states) and a
// zero-wait build, each backed by its own memory array. Expected results come
// from a transaction-level model: legality rules, word index arithmetic, a
// reference copy of memory and a saturating fault counter.
module tb_mem_access_ctrl;

    localparam logic [31:0] BASE  = 32'd1024;
    localparam int          DEPTH = 64;
    localparam logic [31:0] LAST  = BASE + 32'(4 * DEPTH) - 32'd4;

    logic        clk;
    logic        rst;
    logic        r_en  [2];
    logic        w_en  [2];
    logic [31:0] alu   [2];
    logic [31:0] rmv   [2];
    logic [31:0] rdata [2];
    logic [5:0]  maddr [2];
    logic [31:0] wdata [2];
    logic        we    [2];
    logic        re    [2];
    logic [31:0] dmem  [2];
    logic        frz   [2];
    logic        flt   [2];
    logic [7:0]  fcnt  [2];

    logic [31:0] mem     [2][DEPTH];
    logic [31:0] ref_mem [2][DEPTH];
    int          fm      [2];

    logic        poke_en;
    logic [5:0]  poke_a;
    logic [31:0] poke_v;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int we_cyc  = 0;

    mem_access_ctrl #(.BASE_ADDR(BASE), .DEPTH_WORDS(DEPTH), .WAIT_CYCLES(2)) u_dut0 (
        .clk(clk), .rst(rst), .MEM_R_EN(r_en[0]), .MEM_W_EN(w_en[0]),
        .alu_res(alu[0]), .rm_val(rmv[0]), .mem_rdata(rdata[0]),
        .mem_addr(maddr[0]), .mem_wdata(wdata[0]), .mem_we(we[0]), .mem_re(re[0]),
        .data_mem(dmem[0]), .freeze(frz[0]), .addr_fault(flt[0]), .fault_cnt(fcnt[0])
    );

    mem_access_ctrl #(.BASE_ADDR(BASE), .DEPTH_WORDS(DEPTH), .WAIT_CYCLES(0)) u_dut1 (
        .clk(clk), .rst(rst), .MEM_R_EN(r_en[1]), .MEM_W_EN(w_en[1]),
        .alu_res(alu[1]), .rm_val(rmv[1]), .mem_rdata(rdata[1]),
        .mem_addr(maddr[1]), .mem_wdata(wdata[1]), .mem_we(we[1]), .mem_re(re[1]),
        .data_mem(dmem[1]), .freeze(frz[1]), .addr_fault(flt[1]), .fault_cnt(fcnt[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Memory arrays: combinational read, write commits on the falling edge.
    assign rdata[0] = mem[0][maddr[0]];
    assign rdata[1] = mem[1][maddr[1]];

    always @(negedge clk) begin
        if (poke_en) begin
            mem[0][poke_a] <= poke_v;
            mem[1][poke_a] <= poke_v;
        end
        if (we[0]) mem[0][maddr[0]] <= wdata[0];
        if (we[1]) mem[1][maddr[1]] <= wdata[1];
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int wcs(input int d);
        return (d == 0) ? 2 : 0;
    endfunction

    // One instruction in the MEM stage; called #1 after a posedge and
    // returns #1 after the posedge on which the pipeline advances.
    task automatic access(input int d, input bit rd, input bit wr,
                          input logic [31:0] addr, input logic [31:0] data);
        bit         legal;
        logic [5:0] idx;
        int         n, nf;
        bit         done;
        legal = (rd != wr) && (addr >= BASE) && (addr <= LAST) && (addr[1:0] == 2'b00);
        idx   = 6'((addr - BASE) / 4);
        r_en[d] = rd; w_en[d] = wr; alu[d] = addr; rmv[d] = data;
        if (!rd && !wr) begin
            @(negedge clk);
            chk("idle_frz", 32'(frz[d]), 32'd0);
            chk("idle_flt", 32'(flt[d]), 32'd0);
            chk("idle_we",  32'(we[d] | re[d]), 32'd0);
            @(posedge clk); #1;
            chk("idle_fcnt", 32'(fcnt[d]), 32'(fm[d]));
        end else if (!legal) begin
            @(negedge clk);
            chk("flt_set", 32'(flt[d]), 32'd1);
            chk("flt_frz", 32'(frz[d]), 32'd0);
            chk("flt_nomem", 32'(we[d] | re[d]), 32'd0);
            @(posedge clk); #1;
            if (fm[d] < 255) fm[d]++;
            chk("flt_cnt", 32'(fcnt[d]), 32'(fm[d]));
        end else begin
            n = 0; nf = 0; done = 0;
            while (!done && n < 40) begin
                @(negedge clk);
                n++;
                chk("we_re_excl", 32'(we[d] & re[d]), 32'd0);
                if (n == 1) chk("legal_noflt", 32'(flt[d]), 32'd0);
                if (frz[d]) begin
                    nf++;
                    chk("frz_no_we", 32'(we[d]), 32'd0);
                    if (n > 1) begin
                        chk("wait_addr", 32'(maddr[d]), 32'(idx));
                        chk("wait_re", 32'(re[d]), 32'(rd));
                    end
                end else begin
                    done = 1;
                    chk("done_we", 32'(we[d]), 32'(wr));
                    chk("done_addr", 32'(maddr[d]), 32'(idx));
                    if (wr) begin
                        chk("done_wdata", wdata[d], data);
                        we_cyc = cyc;
                    end
                    if (rd && wcs(d) > 0) chk("done_ld", dmem[d], ref_mem[d][idx]);
                end
            end
            if (!done) chk("timeout", 32'd0, 32'd1);
            chk("latency", 32'(n), 32'(wcs(d) + 2));
            chk("frz_cycles", 32'(nf), 32'(wcs(d) + 1));
            @(posedge clk); #1;
            if (rd) chk("load_data", dmem[d], ref_mem[d][idx]);
            if (wr) begin
                ref_mem[d][idx] = data;
                chk("mem_commit", mem[d][idx], data);
            end
        end
        r_en[d] = 1'b0; w_en[d] = 1'b0; alu[d] = '0; rmv[d] = '0;
    endtask

    task automatic rand_op(input int d);
        int k;
        logic [31:0] a;
        k = $urandom_range(0, 9);
        a = BASE + 4 * $urandom_range(0, DEPTH - 1);
        case (k)
            0, 1, 2: access(d, 1, 0, a, 32'd0);
            3, 4, 5: access(d, 0, 1, a, $urandom);
            6:       access(d, 0, 0, a, 32'd0);
            7:       access(d, 1, 0, 32'($urandom_range(0, 1023)), 32'd0);
            8:       access(d, 0, 1, LAST + 32'($urandom_range(1, 5000)), $urandom);
            default: begin
                if ($urandom_range(0, 1) == 0) access(d, 1, 0, a + 32'($urandom_range(1, 3)), 32'd0);
                else                           access(d, 1, 1, a, $urandom);
            end
        endcase
    endtask

    initial begin
        logic [31:0] v;
        int t0;
        rst = 1'b0; poke_en = 1'b0; poke_a = '0; poke_v = '0;
        for (int d = 0; d < 2; d++) begin
            r_en[d] = 0; w_en[d] = 0; alu[d] = '0; rmv[d] = '0; fm[d] = 0;
        end
        // Preload memories (word 0 holds 5) while reset is held.
        for (int a = 0; a < DEPTH; a++) begin
            @(posedge clk); #1;
            v = (a == 0) ? 32'd5 : $urandom;
            poke_en = 1'b1; poke_a = 6'(a); poke_v = v;
            ref_mem[0][a] = v; ref_mem[1][a] = v;
        end
        @(posedge clk); #1;
        poke_en = 1'b0;
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk("rst_frz", 32'(frz[d]), 32'd0);
            chk("rst_strobes", 32'({we[d], re[d], flt[d]}), 32'd0);
            chk("rst_addr", 32'(maddr[d]), 32'd0);
            chk("rst_wdata", wdata[d], 32'd0);
            chk("rst_dmem", dmem[d], 32'd0);
            chk("rst_fcnt", 32'(fcnt[d]), 32'd0);
        end
        rst = 1'b1;
        @(posedge clk); #1;

        // Reset in the middle of a store's WAIT state discards the store.
        w_en[0] = 1'b1; alu[0] = 32'd1028; rmv[0] = 32'h1234_5678;
        @(negedge clk);
        chk("pre_rst_frz", 32'(frz[0]), 32'd1);
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        chk("async_rst_addr", 32'(maddr[0]), 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("inrst_we", 32'(we[0]), 32'd0);
            chk("inrst_frz", 32'(frz[0] | flt[0] | re[0]), 32'd0);
        end
        chk("inrst_wdata", wdata[0], 32'd0);
        w_en[0] = 1'b0; alu[0] = '0; rmv[0] = '0;
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("postrst_we", 32'(we[0]), 32'd0);
        end
        chk("rst_word1", mem[0][1], ref_mem[0][1]);
        @(posedge clk); #1;

        // Store then load, default build.
        access(0, 0, 1, 32'd1032, 32'hDEAD_BEEF);
        access(0, 1, 0, 32'd1032, 32'd0);
        chk("ld_deadbeef", dmem[0], 32'hDEAD_BEEF);

        // Window boundaries.
        access(0, 0, 1, 32'd1276, 32'hCAFE_0063);
        access(0, 1, 0, 32'd1276, 32'd0);
        chk("top_word", mem[0][63], 32'hCAFE_0063);
        access(0, 1, 0, 32'd1280, 32'd0);
        access(0, 0, 1, 32'd1020, 32'h1);
        access(0, 1, 0, 32'd1026, 32'd0);
        chk("fcnt_three", 32'(fcnt[0]), 32'd3);
        access(0, 1, 1, 32'd1024, 32'h2);
        access(0, 1, 0, 32'hFFFF_FFFC, 32'd0);

        for (int i = 0; i < 60; i++) rand_op(0);

        // Saturate the fault counter.
        for (int i = 0; i < 260; i++) access(0, 1, 0, 32'd1026, 32'd0);
        chk("fcnt_sat", 32'(fcnt[0]), 32'd255);
        access(0, 1, 0, 32'd1024, 32'd0);
        chk("fcnt_hold", 32'(fcnt[0]), 32'd255);

        // Zero-wait build.
        access(1, 1, 0, 32'd1024, 32'd0);
        chk("zw_ld5", dmem[1], 32'd5);
        access(1, 0, 1, 32'd1024, 32'hA0A0_0001);
        t0 = we_cyc;
        access(1, 0, 1, 32'd1028, 32'hA0A0_0002);
        chk("b2b_gap", 32'(we_cyc - t0), 32'd2);
        access(1, 1, 0, 32'd1028, 32'd0);
        chk("zw_ld_b", dmem[1], 32'hA0A0_0002);
        access(1, 0, 0, 32'd0, 32'd0);
        chk("ld_hold_idle", dmem[1], 32'hA0A0_0002);
        for (int i = 0; i < 30; i++) rand_op(1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
- Multi-cycle access controller between the EXE/MEM pipeline register and the data memory array.
- Checks each load/store address for range and alignment, converts the byte address into a word index, and sequences the access through a wait-state FSM.
- Asserts freeze so the pipeline holds the MEM-stage instruction until the access completes.
- Presents load data to the MEM/WB register.

Parameters:
BASE_ADDR, 1024, byte address of word 0 of data memory.
DEPTH_WORDS, 64, number of 32-bit words in data memory; power of two.
WAIT_CYCLES, 2, extra wait cycles per access; legal range 0..15.

Ports:
clk  in  1  clock; all state updates on posedge.
rst  in  1  asynchronous, active-low reset.
MEM_R_EN  in  1  load request from EXE/MEM register.
MEM_W_EN  in  1  store request from EXE/MEM register.
alu_res  in  32  byte address computed by EXE.
rm_val  in  32  store data.
mem_rdata  in  32  read data from memory array, combinational from mem_addr.
mem_addr  out  log2(DEPTH_WORDS)  word index to memory array.
mem_wdata  out  32  write data to memory array.
mem_we  out  1  memory write strobe.
mem_re  out  1  memory read enable.
data_mem  out  32  load result to MEM/WB register.
freeze  out  1  pipeline hold: PC, IF/ID, ID/EXE and EXE/MEM registers do not update while high.
addr_fault  out  1  current request is illegal; asserted combinationally.
fault_cnt  out  8  saturating count of faulted requests.

Behaviour:
- Reset (rst=0, asynchronous):
  - State goes to IDLE.
  - mem_addr, mem_wdata, data_mem, fault_cnt, and all latches clear to 0.
  - mem_we, mem_re, freeze and addr_fault are 0.
  - A store latched before reset is discarded and never written.
- Request: req = MEM_R_EN | MEM_W_EN, sampled only in IDLE.
- Legal request, all of:
  - exactly one of MEM_R_EN / MEM_W_EN is set;
  - BASE_ADDR <= alu_res <= BASE_ADDR + 4*DEPTH_WORDS - 4;
  - alu_res[1:0] == 0.
  Comparisons are unsigned 32-bit.
- Word index = (alu_res - BASE_ADDR) >> 2, truncated to log2(DEPTH_WORDS) bits.
- Illegal request in IDLE:
  - addr_fault=1 in that cycle; freeze=0; no memory access.
  - fault_cnt increments on the next posedge and saturates at 255.
  - Stays in IDLE.
- FSM states: IDLE, WAIT, DONE.
- IDLE with a legal request:
  - freeze=1 combinationally.
  - At posedge: latch index, rm_val and op; load wcnt=WAIT_CYCLES.
  - Next state is WAIT if WAIT_CYCLES>0, else DONE.
- WAIT:
  - freeze=1; mem_addr = latched index.
  - mem_re=1 for loads; wcnt decrements each cycle.
  - When wcnt==1 and the op is a load: capture mem_rdata into data_mem at posedge; next state DONE.
- DONE:
  - freeze=0. mem_we=1 for stores, with the latched mem_addr/mem_wdata; the array commits on that cycle's negedge.
  - Loads: data_mem already valid. With WAIT_CYCLES=0, the load captures mem_rdata at the DONE posedge instead, and data_mem is held for the following cycle.
  - Next state IDLE. The pipeline advances at the posedge that ends DONE.
- Latency: a legal access occupies the MEM stage for WAIT_CYCLES+2 cycles; freeze is high for WAIT_CYCLES+1 of them.
- data_mem holds the last load value until the next load capture. It is not cleared by stores or idle cycles.
- Inputs are ignored outside IDLE; the frozen EXE/MEM register keeps them stable.
- mem_we is never high outside DONE. mem_we and mem_re are never high together.
- Highest legal address (BASE_ADDR+252 with defaults) maps to index 63, with no wrap.
- alu_res < BASE_ADDR faults; the subtraction wrap never reaches mem_addr.

Test Plan:
- Reset: hold rst=0 for 3 cycles during a WAIT state of a store to 1028 -> all outputs 0, state IDLE, mem_we never asserted, memory word 1 unchanged.
- Store then load, defaults: MEM_W_EN, alu_res=1032, rm_val=0xDEADBEEF -> freeze high 3 cycles, mem_we=1 exactly in cycle 4 with mem_addr=2. Then MEM_R_EN at 1032 -> data_mem=0xDEADBEEF in DONE, freeze high 3 cycles.
- Boundaries:
  - alu_res=1276 -> index 63, no fault.
  - alu_res=1280 -> addr_fault=1, freeze=0.
  - alu_res=1020 -> fault.
  - alu_res=1026 (misaligned) -> fault.
  - fault_cnt=3 after the three faults.
- Both enables set, alu_res=1024 -> addr_fault=1, no mem_we/mem_re. Driving 260 faults -> fault_cnt saturates at 255.
- WAIT_CYCLES=0 build: load at 1024 holding 0x5 -> freeze high 1 cycle, data_mem=0x5 the cycle after DONE. Back-to-back stores to 1024 and 1028 -> mem_we pulses two cycles apart.
